// File: rtl/insn_loader.sv
// ---------------------------------------------------------------------------
// insn_loader
//   Boot-time writer for the 16 x 2^ADDR_W instruction memory read by the
//   pipeline's IF stage. A byte stream arrives over a valid/ready handshake:
//     <N> { <hi> <lo> } x N <csum>
//   N is the word count (0 means 256). Each hi/lo pair is written big-endian
//   to consecutive addresses starting at BASE_ADDR (wrapping). csum is the
//   XOR of every hi and lo byte; a mismatch or an idle-stream timeout raises
//   the sticky err flag. The CPU pipeline is held for the whole load.
//
// Ports
//   clk       in   1       system clock
//   rst_n     in   1       synchronous reset, active-low
//   start     in   1       pulse: begin a load (ignored while busy)
//   in_valid  in   1       byte available on in_data
//   in_data   in   8       stream byte
//   in_ready  out  1       loader accepts in_data this cycle
//   we        out  1       instruction-memory write enable (1 cycle per word)
//   wa        out  ADDR_W  instruction-memory write address
//   wd        out  16      instruction-memory write data
//   cpu_hold  out  1       1 while busy; gates PC/pipeline advance
//   busy      out  1       loader is not idle
//   done      out  1       1-cycle pulse at end of load (success or failure)
//   err       out  1       sticky checksum/timeout error, cleared by next start
// ---------------------------------------------------------------------------
module insn_loader #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [15:0]       wd,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CSUM,
        S_DONE
    } state_t;

    // Idle counter only needs to reach TIMEOUT_CYC-1; it saturates there.
    localparam int            TW      = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    // The counter reaches TIMEOUT_CYC-1 on the edge after it holds this value,
    // so the abort is taken on that same edge.
    localparam logic [TW-1:0] TO_FIRE = TW'(TIMEOUT_CYC - 2);

    state_t        state;
    state_t        state_d;
    logic [7:0]    n_words;   // 0 encodes 256 words
    logic [7:0]    idx;       // words written so far in this load
    logic [7:0]    hi;
    logic [7:0]    csum;
    logic [TW-1:0] tcnt;

    logic active;
    logic accept;
    logic last_word;
    logic timeout_hit;

    // States that wait on the byte stream; derived from state alone so the
    // handshake never depends combinationally on in_valid.
    assign active = (state == S_COUNT) || (state == S_HI) ||
                    (state == S_LO)    || (state == S_CSUM);
    assign accept      = in_valid & active;
    // 8-bit wrap makes N=0 terminate after the 256th word.
    assign last_word   = ((idx + 8'd1) == n_words);
    // An accept in the same cycle wins over the timeout.
    assign timeout_hit = active & ~accept & (tcnt >= TO_FIRE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        in_ready = 1'b0;
        we       = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_COUNT;
            end
            S_COUNT: begin
                in_ready = 1'b1;
                if (accept)           state_d = S_HI;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_HI: begin
                in_ready = 1'b1;
                if (accept)           state_d = S_LO;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_LO: begin
                in_ready = 1'b1;
                if (accept)           state_d = S_WRITE;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_WRITE: begin
                we      = 1'b1;
                state_d = last_word ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (accept || timeout_hit) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign cpu_hold = busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_words <= '0;
            idx     <= '0;
            hi      <= '0;
            csum    <= '0;
            tcnt    <= '0;
            wa      <= BASE_ADDR;
            wd      <= '0;
            err     <= 1'b0;
        end else begin
            if (state == S_IDLE || accept) begin
                tcnt <= '0;
            end else if (tcnt != TO_LAST) begin
                tcnt <= tcnt + TW'(1);
            end

            if (timeout_hit) err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        err  <= 1'b0;
                        idx  <= '0;
                        csum <= '0;
                    end
                end
                S_COUNT: begin
                    if (accept) n_words <= in_data;
                end
                S_HI: begin
                    if (accept) begin
                        hi   <= in_data;
                        csum <= csum ^ in_data;
                    end
                end
                S_LO: begin
                    // Address and data are registered here so they are stable
                    // for the whole WRITE cycle and held afterwards.
                    if (accept) begin
                        wd   <= {hi, in_data};
                        wa   <= BASE_ADDR + ADDR_W'(idx);
                        csum <= csum ^ in_data;
                    end
                end
                S_WRITE: begin
                    idx <= idx + 8'd1;
                end
                S_CSUM: begin
                    if (accept) err <= (in_data != csum);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_loader.sv
// ---------------------------------------------------------------------------
// tb_insn_loader
//   Two loaders (BASE_ADDR 00 and FF, TIMEOUT_CYC 16) driven in lockstep by
//   the same byte stream. A transaction-level model turns each stream into the
//   list of (address, data) writes and the final err value; one negedge
//   process compares every write, done pulse and idle/busy flag against it.
// ---------------------------------------------------------------------------
module tb_insn_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        in_ready [2];
    logic        we       [2];
    logic [7:0]  wa       [2];
    logic [15:0] wd       [2];
    logic        cpu_hold [2];
    logic        busy     [2];
    logic        done     [2];
    logic        err      [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        insn_loader #(
            .ADDR_W      (8),
            .BASE_ADDR   ((g == 0) ? 8'h00 : 8'hFF),
            .TIMEOUT_CYC (16)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .in_valid (in_valid),
            .in_data  (in_data),
            .in_ready (in_ready[g]),
            .we       (we[g]),
            .wa       (wa[g]),
            .wd       (wd[g]),
            .cpu_hold (cpu_hold[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .err      (err[g])
        );
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]  base_of [2] = '{8'h00, 8'hFF};
    logic [23:0] exp_q   [2][$];   // expected {addr, data} writes
    logic [23:0] log_q   [2][$];   // observed writes of the current load
    logic        exp_err_done = 1'b0;
    logic        sticky_err [2] = '{1'b0, 1'b0};
    logic        prev_done  [2] = '{1'b0, 1'b0};
    logic        prev_acc = 1'b0;
    logic [23:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                exp_q[i].delete();
                sticky_err[i] = 1'b0;
                prev_done[i]  = 1'b0;
            end
            prev_acc = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                check("hold_eq_busy", cpu_hold[i], busy[i]);
                if (we[i]) begin
                    check("we_ready_low", in_ready[i], 0);
                    check("we_after_lo", prev_acc, 1);
                    if (exp_q[i].size() == 0) begin
                        check("spurious_we", we[i], 0);
                    end else begin
                        mon_e = exp_q[i].pop_front();
                        check("wa", wa[i], mon_e[23:16]);
                        check("wd", wd[i], mon_e[15:0]);
                    end
                    log_q[i].push_back({wa[i], wd[i]});
                end
                if (done[i]) begin
                    check("done_err", err[i], exp_err_done);
                    check("done_single", prev_done[i], 0);
                    check("done_busy", busy[i], 1);
                    sticky_err[i] = exp_err_done;
                end else if (busy[i]) begin
                    check("err_cleared", err[i], 0);
                end else begin
                    check("err_sticky", err[i], sticky_err[i]);
                    check("idle_we", we[i], 0);
                    check("idle_ready", in_ready[i], 0);
                end
                prev_done[i] = done[i];
            end
            check("lockstep_busy", busy[1], busy[0]);
            prev_acc = in_valid & in_ready[0];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int t;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) begin
            in_data = 8'($urandom);       // junk while invalid must be ignored
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready[0]) break;
            t++;
            if (t > 40) begin
                check("ready_timeout", in_ready[0], 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        for (t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done[0]) break;
        end
        check("done_seen", done[0], 1);
        @(negedge clk);
        check("hold_released", cpu_hold[0], 0);
        @(posedge clk);
        #1;
    endtask

    // Model: expected writes and err from the stream alone.
    task automatic run_load(input logic [7:0] bytes[$], input int max_gap, input bit hold_start);
        int         nw;
        logic [7:0] cs;
        nw = (bytes[0] == 8'h00) ? 256 : int'(bytes[0]);
        cs = 8'h00;
        for (int i = 0; i < nw; i++) begin
            cs = cs ^ bytes[1 + 2*i] ^ bytes[2 + 2*i];
            for (int g = 0; g < 2; g++)
                exp_q[g].push_back({8'(base_of[g] + 8'(i)), bytes[1 + 2*i], bytes[2 + 2*i]});
        end
        exp_err_done = (bytes[1 + 2*nw] != cs);
        log_q[0].delete();
        log_q[1].delete();

        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        foreach (bytes[k]) send_byte(bytes[k], max_gap);
        start = 1'b0;
        wait_done();
        check("writes_left", exp_q[0].size() + exp_q[1].size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] q[$];
        logic [7:0] cs;
        logic [7:0] b;
        int         n;
        int         t;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", in_ready[i], 0);
            check("rst_we", we[i], 0);
            check("rst_wa", wa[i], base_of[i]);
            check("rst_wd", wd[i], 0);
            check("rst_hold", cpu_hold[i], 0);
            check("rst_busy", busy[i], 0);
            check("rst_done", done[i], 0);
            check("rst_err", err[i], 0);
        end
        @(posedge clk);
        #1;

        // Two words; the checksum of 12 34 AB CD is 40.
        q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run_load(q, 0, 1'b0);
        check("t1_w0", log_q[0][0], 24'h001234);
        check("t1_w1", log_q[0][1], 24'h01ABCD);
        check("t1_w0_ff", log_q[1][0], 24'hFF1234);
        check("t1_w1_ff", log_q[1][1], 24'h00ABCD);
        check("t1_err", err[0], 0);

        // Wrong checksum, start held high for the whole load.
        q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        run_load(q, 1, 1'b1);
        check("t2_nwrites", log_q[0].size(), 2);
        repeat (4) @(posedge clk);
        #1;
        check("t2_err_sticky", err[0], 1);

        // Address wrap on the FF-based instance.
        q = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03};
        run_load(q, 0, 1'b0);
        check("t3_w0_ff", log_q[1][0], 24'hFF0001);
        check("t3_w1_ff", log_q[1][1], 24'h000002);
        check("t3_err", err[1], 0);

        // Count byte 00: 256 words with randomly gapped valid.
        q = '{8'h00};
        cs = 8'h00;
        for (int i = 0; i < 512; i++) begin
            b = 8'($urandom);
            cs = cs ^ b;
            q.push_back(b);
        end
        q.push_back(cs);
        run_load(q, 3, 1'b0);
        check("t4_nwrites", log_q[0].size(), 256);
        check("t4_last_addr", log_q[0][255][23:16], 8'hFF);
        check("t4_last_addr_ff", log_q[1][255][23:16], 8'hFE);
        check("t4_err", err[0], 0);

        // Short random loads, some with a corrupted checksum.
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 6));
            q = '{8'(n)};
            cs = 8'h00;
            for (int i = 0; i < 2*n; i++) begin
                b = 8'($urandom);
                cs = cs ^ b;
                q.push_back(b);
            end
            q.push_back(($urandom_range(0, 1) == 1) ? cs : (cs ^ 8'h5A));
            run_load(q, 2, 1'($urandom_range(0, 1)));
            check("rnd_nwrites", log_q[0].size(), n);
        end

        // Timeout: stream stalls after the first hi byte.
        exp_err_done = 1'b1;
        log_q[0].delete();
        log_q[1].delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        for (t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (done[0]) break;
        end
        check("t5_timeout_cycle", t, 16);
        check("t5_err", err[0], 1);
        check("t5_no_write", log_q[0].size(), 0);
        @(posedge clk);
        #1;

        // Reset while waiting for a lo byte, with start and valid asserted.
        log_q[0].delete();
        log_q[1].delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        in_valid = 1'b1;
        in_data  = 8'h56;
        rst_n    = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("t6_in_ready", in_ready[i], 0);
            check("t6_we", we[i], 0);
            check("t6_wa", wa[i], base_of[i]);
            check("t6_wd", wd[i], 0);
            check("t6_busy", busy[i], 0);
            check("t6_hold", cpu_hold[i], 0);
            check("t6_done", done[i], 0);
            check("t6_err", err[i], 0);
        end
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_no_write", log_q[0].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
